// File: rtl/cu_pkg.sv
// Shared definitions for the Mini SRC control unit: opcodes, ALU codes,
// sequencer states and instruction classes.
package cu_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BRX  = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_NONE = 5'b00000;
    localparam logic [4:0] ALU_ADD  = 5'b00011;
    localparam logic [4:0] ALU_AND  = 5'b00101;
    localparam logic [4:0] ALU_OR   = 5'b00110;

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        C_RR, C_IMM, C_UN, C_MD, C_LD, C_LDI, C_ST, C_BR, C_ONE, C_NOP, C_HLT
    } iclass_t;

    // Final step of each instruction class; the boundary decision is taken there.
    function automatic state_t last_step(input iclass_t c);
        case (c)
            C_RR, C_IMM, C_LDI: return S_T5;
            C_UN:               return S_T4;
            C_MD, C_BR:         return S_T6;
            C_LD, C_ST:         return S_T7;
            C_ONE:              return S_T3;
            default:            return S_T2;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Bundle between the control unit and the datapath/memory: status inputs
// and every strobe the sequencer drives.
interface control_unit_if;
    logic [31:0] IR;
    logic        CON_FF;
    logic        mem_ready;
    logic        Stop;

    logic PCout, MDRout, ZHighout, ZLowout, HIout, LOout, InPortout, Cout;
    logic PCin, IRin, MARin, MDRin, Yin, ZHIin, ZLOin, HIin, LOin, CONin, OutPortin;
    logic Gra, Grb, Grc, Rin, Rout, BAout;
    logic IncPC, Read, Write;
    logic [4:0] operation;
    logic Run;

    modport master (
        input  IR, CON_FF, mem_ready, Stop,
        output PCout, MDRout, ZHighout, ZLowout, HIout, LOout, InPortout, Cout,
        output PCin, IRin, MARin, MDRin, Yin, ZHIin, ZLOin, HIin, LOin, CONin, OutPortin,
        output Gra, Grb, Grc, Rin, Rout, BAout,
        output IncPC, Read, Write, operation, Run
    );

    modport slave (
        output IR, CON_FF, mem_ready, Stop,
        input  PCout, MDRout, ZHighout, ZLowout, HIout, LOout, InPortout, Cout,
        input  PCin, IRin, MARin, MDRin, Yin, ZHIin, ZLOin, HIin, LOin, CONin, OutPortin,
        input  Gra, Grb, Grc, Rin, Rout, BAout,
        input  IncPC, Read, Write, operation, Run
    );
endinterface

// File: rtl/cu_decode.sv
// Opcode decoder: instruction class plus the ALU code used by the execute steps.
module cu_decode
    import cu_pkg::*;
(
    input  logic [4:0] opcode,
    output iclass_t    iclass,
    output logic [4:0] alu_op
);

    // Classify the opcode; unlisted opcodes behave as nop.
    always_comb begin
        iclass = C_NOP;
        alu_op = ALU_NONE;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA,
            OP_SHL, OP_ROR, OP_ROL: begin
                iclass = C_RR;
                alu_op = opcode;
            end
            OP_ADDI: begin iclass = C_IMM; alu_op = ALU_ADD; end
            OP_ANDI: begin iclass = C_IMM; alu_op = ALU_AND; end
            OP_ORI:  begin iclass = C_IMM; alu_op = ALU_OR;  end
            OP_NEG, OP_NOT: begin
                iclass = C_UN;
                alu_op = opcode;
            end
            OP_MUL, OP_DIV: begin
                iclass = C_MD;
                alu_op = opcode;
            end
            OP_LD:  begin iclass = C_LD;  alu_op = ALU_ADD; end
            OP_LDI: begin iclass = C_LDI; alu_op = ALU_ADD; end
            OP_ST:  begin iclass = C_ST;  alu_op = ALU_ADD; end
            OP_BRX: begin iclass = C_BR;  alu_op = ALU_ADD; end
            OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO: iclass = C_ONE;
            OP_HALT: iclass = C_HLT;
            default: iclass = C_NOP;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multicycle sequencer for the Mini SRC CPU.
//
// state  | meaning
// RST    | reset; all strobes low, Run low
// T0     | fetch: PC to MAR, PC+1 into Z
// T1     | fetch: PC update, memory read (holds until mem_ready)
// T2     | fetch: MDR into IR
// T3..T7 | execute steps, sequence chosen by instruction class
// HALT   | stopped; only clr leaves
module control_unit
    import cu_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 0
) (
    input  logic           clk,
    input  logic           clr,
    control_unit_if.master bus
);

    localparam int WW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX + 1) : 1;
    localparam logic [WW-1:0] WAIT_LOAD = WW'(MEM_WAIT_MAX);
    localparam bit TIMEOUT_EN = (MEM_WAIT_MAX > 0);

    state_t     state, state_next;
    iclass_t    iclass;
    logic [4:0] alu_op;
    logic [4:0] opcode;
    logic       in_wait;
    logic       timeout;
    logic [WW-1:0] wait_left;
    logic       ir_fields_unused;

    assign opcode = bus.IR[31:27];
    // Operand fields are consumed by the datapath, not here.
    assign ir_fields_unused = ^bus.IR[26:0];

    cu_decode u_decode (
        .opcode (opcode),
        .iclass (iclass),
        .alu_op (alu_op)
    );

    // A memory step waits while mem_ready is low: fetch read, ld read, st write.
    assign in_wait = (state == S_T1)
                  || (state == S_T6 && iclass == C_LD)
                  || (state == S_T7 && iclass == C_ST);

    assign timeout = TIMEOUT_EN && in_wait && !bus.mem_ready && (wait_left == WW'(1));

    // State register.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= S_RST;
        else      state <= state_next;
    end

    // Down-counter of remaining tolerated wait cycles; reloads whenever not stalled.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr)                           wait_left <= WAIT_LOAD;
        else if (in_wait && !bus.mem_ready) wait_left <= wait_left - 1'b1;
        else                                wait_left <= WAIT_LOAD;
    end

    // Next-state: hold on memory waits, branch to HALT/T0 at the boundary.
    always_comb begin
        state_next = state;
        case (state)
            S_RST:  state_next = S_T0;
            S_HALT: state_next = S_HALT;
            default: begin
                if (in_wait && !bus.mem_ready)
                    state_next = timeout ? S_HALT : state;
                else if (state == last_step(iclass))
                    state_next = (iclass == C_HLT || bus.Stop) ? S_HALT : S_T0;
                else
                    state_next = state_t'(state + 4'd1);
            end
        endcase
    end

    // Moore strobe decode from state, class, opcode and CON_FF.
    always_comb begin
        bus.PCout = 1'b0;  bus.MDRout = 1'b0; bus.ZHighout = 1'b0; bus.ZLowout = 1'b0;
        bus.HIout = 1'b0;  bus.LOout = 1'b0;  bus.InPortout = 1'b0; bus.Cout = 1'b0;
        bus.PCin = 1'b0;   bus.IRin = 1'b0;   bus.MARin = 1'b0;  bus.MDRin = 1'b0;
        bus.Yin = 1'b0;    bus.ZHIin = 1'b0;  bus.ZLOin = 1'b0;  bus.HIin = 1'b0;
        bus.LOin = 1'b0;   bus.CONin = 1'b0;  bus.OutPortin = 1'b0;
        bus.Gra = 1'b0;    bus.Grb = 1'b0;    bus.Grc = 1'b0;
        bus.Rin = 1'b0;    bus.Rout = 1'b0;   bus.BAout = 1'b0;
        bus.IncPC = 1'b0;  bus.Read = 1'b0;   bus.Write = 1'b0;
        bus.operation = ALU_NONE;
        bus.Run = !(state == S_RST || state == S_HALT);
        case (state)
            S_T0: begin
                bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.ZLOin = 1'b1;
            end
            S_T1: begin
                bus.ZLowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1;
            end
            S_T2: begin
                bus.MDRout = 1'b1; bus.IRin = 1'b1;
            end
            S_T3: begin
                case (iclass)
                    C_RR: begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1; end
                    C_IMM, C_LDI, C_LD, C_ST: begin
                        bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1;
                    end
                    C_UN: begin
                        bus.Grb = 1'b1; bus.Rout = 1'b1; bus.ZLOin = 1'b1;
                        bus.operation = alu_op;
                    end
                    C_MD: begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1; end
                    C_BR: begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.CONin = 1'b1; end
                    C_ONE: begin
                        case (opcode)
                            OP_JR:   begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1; end
                            OP_IN:   begin bus.InPortout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                            OP_OUT:  begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.OutPortin = 1'b1; end
                            OP_MFHI: begin bus.HIout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                            OP_MFLO: begin bus.LOout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                case (iclass)
                    C_RR: begin
                        bus.Grc = 1'b1; bus.Rout = 1'b1; bus.ZLOin = 1'b1;
                        bus.operation = alu_op;
                    end
                    C_IMM, C_LDI, C_LD, C_ST: begin
                        bus.Cout = 1'b1; bus.ZLOin = 1'b1; bus.operation = alu_op;
                    end
                    C_UN: begin bus.ZLowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                    C_MD: begin
                        bus.Grb = 1'b1; bus.Rout = 1'b1; bus.ZHIin = 1'b1; bus.ZLOin = 1'b1;
                        bus.operation = alu_op;
                    end
                    C_BR: begin bus.PCout = 1'b1; bus.Yin = 1'b1; end
                    default: ;
                endcase
            end
            S_T5: begin
                case (iclass)
                    C_RR, C_IMM, C_LDI: begin
                        bus.ZLowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
                    end
                    C_LD, C_ST: begin bus.ZLowout = 1'b1; bus.MARin = 1'b1; end
                    C_MD:       begin bus.ZLowout = 1'b1; bus.LOin = 1'b1; end
                    C_BR: begin
                        bus.Cout = 1'b1; bus.ZLOin = 1'b1; bus.operation = alu_op;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                case (iclass)
                    C_LD: begin bus.Read = 1'b1; bus.MDRin = 1'b1; end
                    C_ST: begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1; end
                    C_MD: begin bus.ZHighout = 1'b1; bus.HIin = 1'b1; end
                    C_BR: begin bus.ZLowout = 1'b1; bus.PCin = bus.CON_FF; end
                    default: ;
                endcase
            end
            S_T7: begin
                case (iclass)
                    C_LD: begin bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                    C_ST: bus.Write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a per-instruction step model derived from the
// instruction set's micro-step tables, compared against the DUT every cycle.
module tb_control_unit;

    localparam int WMAX = 6;

    localparam int K_RR = 0, K_IMM = 1, K_UN = 2, K_MD = 3, K_LD = 4, K_LDI = 5;
    localparam int K_ST = 6, K_BR = 7, K_ONE = 8, K_NOP = 9, K_HLT = 10;

    typedef struct packed {
        logic PCout, MDRout, ZHighout, ZLowout, HIout, LOout, InPortout, Cout;
        logic PCin, IRin, MARin, MDRin, Yin, ZHIin, ZLOin, HIin, LOin, CONin, OutPortin;
        logic Gra, Grb, Grc, Rin, Rout, BAout;
        logic IncPC, Read, Write;
        logic [4:0] operation;
        logic Run;
    } vec_t;

    logic clk = 1'b0;
    logic clr;
    control_unit_if bus();

    control_unit #(.MEM_WAIT_MAX(WMAX)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    vec_t act;
    vec_t expv;
    bit   exp_valid = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc_no = 0;

    assign act = {bus.PCout, bus.MDRout, bus.ZHighout, bus.ZLowout, bus.HIout, bus.LOout,
                  bus.InPortout, bus.Cout,
                  bus.PCin, bus.IRin, bus.MARin, bus.MDRin, bus.Yin, bus.ZHIin, bus.ZLOin,
                  bus.HIin, bus.LOin, bus.CONin, bus.OutPortin,
                  bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout, bus.BAout,
                  bus.IncPC, bus.Read, bus.Write, bus.operation, bus.Run};

    // ---------------- behavioural model ----------------
    function automatic int cls(input logic [4:0] op);
        if (op >= 5'd3 && op <= 5'd11)  return K_RR;
        if (op >= 5'd12 && op <= 5'd14) return K_IMM;
        if (op == 5'd17 || op == 5'd18) return K_UN;
        if (op == 5'd15 || op == 5'd16) return K_MD;
        if (op == 5'd0)  return K_LD;
        if (op == 5'd1)  return K_LDI;
        if (op == 5'd2)  return K_ST;
        if (op == 5'd19) return K_BR;
        if (op == 5'd20 || (op >= 5'd22 && op <= 5'd25)) return K_ONE;
        if (op == 5'd27) return K_HLT;
        return K_NOP;
    endfunction

    function automatic logic [4:0] model_alu(input logic [4:0] op);
        int c;
        c = cls(op);
        if (c == K_RR || c == K_UN || c == K_MD) return op;
        if (op == 5'd12) return 5'd3;
        if (op == 5'd13) return 5'd5;
        if (op == 5'd14) return 5'd6;
        if (c == K_LD || c == K_LDI || c == K_ST || c == K_BR) return 5'd3;
        return 5'd0;
    endfunction

    function automatic int model_len(input logic [4:0] op);
        case (cls(op))
            K_RR, K_IMM, K_LDI: return 6;
            K_UN:               return 5;
            K_MD, K_BR:         return 7;
            K_LD, K_ST:         return 8;
            K_ONE:              return 4;
            default:            return 3;
        endcase
    endfunction

    function automatic bit model_wait(input logic [4:0] op, input int k);
        return (k == 1) || (cls(op) == K_LD && k == 6) || (cls(op) == K_ST && k == 7);
    endfunction

    function automatic vec_t model_step(input logic [4:0] op, input logic con, input int k);
        vec_t s;
        int c;
        int e;
        logic [4:0] a;
        s = '0;
        s.Run = 1'b1;
        c = cls(op);
        a = model_alu(op);
        e = k - 3;
        if (k == 0) begin
            s.PCout = 1'b1; s.MARin = 1'b1; s.IncPC = 1'b1; s.ZLOin = 1'b1;
        end else if (k == 1) begin
            s.ZLowout = 1'b1; s.PCin = 1'b1; s.Read = 1'b1; s.MDRin = 1'b1;
        end else if (k == 2) begin
            s.MDRout = 1'b1; s.IRin = 1'b1;
        end else begin
            case (c)
                K_RR: begin
                    if (e == 0) begin s.Grb = 1'b1; s.Rout = 1'b1; s.Yin = 1'b1; end
                    else if (e == 1) begin s.Grc = 1'b1; s.Rout = 1'b1; s.ZLOin = 1'b1; s.operation = a; end
                    else begin s.ZLowout = 1'b1; s.Gra = 1'b1; s.Rin = 1'b1; end
                end
                K_IMM, K_LDI, K_LD, K_ST: begin
                    if (e == 0) begin s.Grb = 1'b1; s.BAout = 1'b1; s.Yin = 1'b1; end
                    else if (e == 1) begin s.Cout = 1'b1; s.ZLOin = 1'b1; s.operation = a; end
                    else if (e == 2) begin
                        s.ZLowout = 1'b1;
                        if (c == K_IMM || c == K_LDI) begin s.Gra = 1'b1; s.Rin = 1'b1; end
                        else s.MARin = 1'b1;
                    end else if (e == 3) begin
                        s.MDRin = 1'b1;
                        if (c == K_LD) s.Read = 1'b1;
                        else begin s.Gra = 1'b1; s.Rout = 1'b1; end
                    end else begin
                        if (c == K_LD) begin s.MDRout = 1'b1; s.Gra = 1'b1; s.Rin = 1'b1; end
                        else s.Write = 1'b1;
                    end
                end
                K_UN: begin
                    if (e == 0) begin s.Grb = 1'b1; s.Rout = 1'b1; s.ZLOin = 1'b1; s.operation = a; end
                    else begin s.ZLowout = 1'b1; s.Gra = 1'b1; s.Rin = 1'b1; end
                end
                K_MD: begin
                    if (e == 0) begin s.Gra = 1'b1; s.Rout = 1'b1; s.Yin = 1'b1; end
                    else if (e == 1) begin
                        s.Grb = 1'b1; s.Rout = 1'b1; s.ZHIin = 1'b1; s.ZLOin = 1'b1; s.operation = a;
                    end else if (e == 2) begin s.ZLowout = 1'b1; s.LOin = 1'b1; end
                    else begin s.ZHighout = 1'b1; s.HIin = 1'b1; end
                end
                K_BR: begin
                    if (e == 0) begin s.Gra = 1'b1; s.Rout = 1'b1; s.CONin = 1'b1; end
                    else if (e == 1) begin s.PCout = 1'b1; s.Yin = 1'b1; end
                    else if (e == 2) begin s.Cout = 1'b1; s.ZLOin = 1'b1; s.operation = 5'd3; end
                    else begin s.ZLowout = 1'b1; s.PCin = con; end
                end
                K_ONE: begin
                    case (op)
                        5'd20: begin s.Gra = 1'b1; s.Rout = 1'b1; s.PCin = 1'b1; end
                        5'd22: begin s.InPortout = 1'b1; s.Gra = 1'b1; s.Rin = 1'b1; end
                        5'd23: begin s.Gra = 1'b1; s.Rout = 1'b1; s.OutPortin = 1'b1; end
                        5'd24: begin s.HIout = 1'b1; s.Gra = 1'b1; s.Rin = 1'b1; end
                        5'd25: begin s.LOout = 1'b1; s.Gra = 1'b1; s.Rin = 1'b1; end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
        return s;
    endfunction

    // ---------------- compare process ----------------
    task automatic pin(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL model %s: got=%0d want=%0d", name, got, want);
        end
    endtask

    // Literal pins of the model, then per-cycle DUT comparison.
    initial begin
        vec_t p;
        pin("len_add", model_len(5'd3), 6);
        pin("len_nop", model_len(5'd26), 3);
        pin("len_jr", model_len(5'd20), 4);
        pin("len_neg", model_len(5'd17), 5);
        pin("len_mul", model_len(5'd15), 7);
        pin("len_brx", model_len(5'd19), 7);
        pin("len_ld", model_len(5'd0), 8);
        pin("len_st", model_len(5'd2), 8);
        pin("len_ldi", model_len(5'd1), 6);
        pin("alu_andi", int'(model_alu(5'd13)), 5);
        pin("alu_ori", int'(model_alu(5'd14)), 6);
        p = model_step(5'd0, 1'b0, 2);
        pin("fetch_t2_irin", int'(p.IRin), 1);
        p = model_step(5'd3, 1'b0, 4);
        pin("add_t4", int'({p.Grc, p.Rout, p.operation}), 7'b1100011);
        p = model_step(5'd15, 1'b0, 4);
        pin("mul_t4", int'({p.ZHIin, p.ZLOin, p.operation}), 7'b1101111);
        p = model_step(5'd19, 1'b0, 6);
        pin("brx0_t6", int'({p.ZLowout, p.PCin}), 2'b10);
        p = model_step(5'd19, 1'b1, 6);
        pin("brx1_t6", int'({p.ZLowout, p.PCin}), 2'b11);
        forever begin
            @(negedge clk);
            if (exp_valid) begin
                total++;
                if (act !== expv) begin
                    bad++;
                    $display("FAIL outputs cycle %0d: got=%h want=%h", cyc_no, act, expv);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input vec_t e, input logic [31:0] ir, input logic con,
                       input logic mr, input logic stp, input logic clr_v);
        @(posedge clk);
        #2;
        bus.IR = ir;
        bus.CON_FF = con;
        bus.mem_ready = mr;
        bus.Stop = stp;
        clr = clr_v;
        expv = e;
        exp_valid = 1'b1;
        cyc_no++;
    endtask

    function automatic logic rbit();
        return logic'($urandom_range(0, 1));
    endfunction

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cyc('0, 32'd0, rbit(), rbit(), rbit(), 1'b0);
        cyc('0, 32'd0, rbit(), rbit(), rbit(), 1'b1);
    endtask

    task automatic halt_hold(input int n);
        for (int i = 0; i < n; i++) cyc('0, $urandom, rbit(), rbit(), rbit(), 1'b1);
    endtask

    // status: 0 next instruction follows, 1 halted, 2 aborted by clr
    task automatic run_instr(input logic [4:0] op, input logic con, input bit stop_req,
                             input int w1, input int wm, input bit stop_mid,
                             input bit abort, output int status);
        logic [31:0] ir;
        int n;
        int reps;
        vec_t s;
        logic stp;
        ir = {op, 27'($urandom)};
        n = model_len(op);
        status = 0;
        for (int k = 0; k < n; k++) begin
            s = model_step(op, con, k);
            if (model_wait(op, k)) begin
                reps = (k == 1) ? w1 : wm;
                for (int j = 0; j < reps; j++) begin
                    if (abort && k != 1 && j == 1) begin
                        cyc('0, ir, con, 1'b0, rbit(), 1'b0);
                        status = 2;
                        return;
                    end
                    cyc(s, ir, con, 1'b0, stop_mid ? 1'b1 : rbit(), 1'b1);
                    if (j + 1 == WMAX) begin
                        status = 1;
                        return;
                    end
                end
                stp = (k == n - 1) ? stop_req : (stop_mid ? 1'b1 : rbit());
                cyc(s, ir, con, 1'b1, stp, 1'b1);
            end else begin
                stp = (k == n - 1) ? stop_req : (stop_mid ? 1'b1 : rbit());
                cyc(s, ir, con, rbit(), stp, 1'b1);
            end
        end
        if (op == 5'd27 || stop_req) status = 1;
    endtask

    task automatic instr(input logic [4:0] op, input logic con, input bit stop_req,
                         input int w1, input int wm, input bit stop_mid, input bit abort);
        int st;
        run_instr(op, con, stop_req, w1, wm, stop_mid, abort, st);
        if (st == 1) begin
            halt_hold(4);
            do_reset(2);
        end else if (st == 2) begin
            do_reset(2);
        end
    endtask

    initial begin
        clr = 1'b0;
        bus.IR = 32'd0;
        bus.CON_FF = 1'b0;
        bus.mem_ready = 1'b1;
        bus.Stop = 1'b0;
        do_reset(3);

        instr(5'd3,  1'b0, 1'b0, 0, 0, 1'b0, 1'b0);   // add
        instr(5'd4,  1'b0, 1'b0, 0, 0, 1'b1, 1'b0);   // sub, Stop high mid-instruction only
        instr(5'd0,  1'b0, 1'b0, 0, 3, 1'b0, 1'b0);   // ld, three wait cycles
        instr(5'd19, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);   // brx, not taken
        instr(5'd19, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);   // brx, taken
        instr(5'd15, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);   // mul
        instr(5'd2,  1'b0, 1'b0, 2, 2, 1'b0, 1'b0);   // st with waits
        instr(5'd0,  1'b0, 1'b0, 0, 3, 1'b0, 1'b1);   // ld aborted by clr mid-wait
        instr(5'd6,  1'b0, 1'b1, 0, 0, 1'b0, 1'b0);   // or, Stop at boundary
        instr(5'd3,  1'b0, 1'b0, WMAX, 0, 1'b0, 1'b0); // fetch timeout
        instr(5'd27, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);   // halt opcode

        for (int i = 0; i < 400; i++) begin
            instr(5'($urandom_range(0, 31)), rbit(),
                  ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                  1'b0, ($urandom_range(0, 39) == 0));
        end

        @(posedge clk);
        #2;
        exp_valid = 1'b0;
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
